// File: rtl/num_classify_stream_if.sv
// num_classify_stream_if
//   Bundles the number-in / result-out handshakes of num_classify_stream.
//   Handshake rule for both channels: a transfer happens on a rising clk
//   edge where valid && ready are both 1; the sender holds valid and its
//   payload stable until that edge, and ready never depends on valid.
//   Signals:
//     in_valid/in_ready/in_num    number channel (source -> classifier)
//     out_valid/out_ready         result channel (classifier -> consumer)
//     out_num/out_even/out_div/out_rem   result payload
//     even_cnt/odd_cnt            running saturating totals
//     dbg_state                   classifier FSM state (0 IDLE, 1 CALC, 2 DONE)
//   Modports: slave = classifier side, master = source/consumer side.
interface num_classify_stream_if #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_num;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_num;
    logic             out_even;
    logic             out_div;
    logic [WIDTH-1:0] out_rem;
    logic [CNT_W-1:0] even_cnt;
    logic [CNT_W-1:0] odd_cnt;
    logic [1:0]       dbg_state;

    modport slave (
        input  in_valid, in_num, out_ready,
        output in_ready, out_valid, out_num, out_even, out_div, out_rem,
               even_cnt, odd_cnt, dbg_state
    );

    modport master (
        output in_valid, in_num, out_ready,
        input  in_ready, out_valid, out_num, out_even, out_div, out_rem,
               even_cnt, odd_cnt, dbg_state
    );
endinterface

// File: rtl/num_classify_stream.sv
// num_classify_stream
//   Streaming number classifier. Accepts one WIDTH-bit number per input
//   handshake, computes num mod DIVISOR with an MSB-first restoring
//   shift-subtract divider (one bit per cycle, WIDTH cycles), then presents
//   the number, even/odd, divisible flag and remainder until the consumer
//   takes them. Even/odd totals count delivered results and saturate.
//   Ports:
//     clk  rising-edge clock
//     rst  asynchronous active-high reset
//     bus  num_classify_stream_if.slave (in_*, out_*, counters, dbg_state)
//   Parameters: WIDTH (>=2), DIVISOR (>=1), CNT_W (counter width).
//   Optional: define NUM_CLASSIFY_DISPLAY_EN to print one simulation line
//   per delivered result; behaviour is otherwise identical.
module num_classify_stream #(
    parameter int              WIDTH   = 32,
    parameter longint unsigned DIVISOR = 3,
    parameter int              CNT_W   = 16
) (
    input logic                  clk,
    input logic                  rst,
    num_classify_stream_if.slave bus
);
    localparam int             IDX_W   = $clog2(WIDTH);
    localparam logic [WIDTH:0] DIV_EXT = (WIDTH+1)'(DIVISOR);

    generate
        if (DIVISOR == 0) begin : g_bad_divisor
            $error("num_classify_stream: DIVISOR must be at least 1");
        end
        if (WIDTH < 2) begin : g_bad_width
            $error("num_classify_stream: WIDTH must be at least 2");
        end
    endgenerate

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] operand;
    // Partial remainder is always < DIVISOR, so WIDTH bits hold it; the
    // shifted trial value needs the extra bit.
    logic [WIDTH-1:0] rem;
    logic [IDX_W-1:0] idx;
    logic [WIDTH:0]   shifted;
    logic [WIDTH:0]   rem_next;

    always_comb begin
        shifted  = {rem, operand[idx]};
        rem_next = shifted;
        if (shifted >= DIV_EXT) begin
            rem_next = shifted - DIV_EXT;
        end
    end

    // Decoded from the state register only, so never depends on in_valid.
    assign bus.in_ready  = (state == IDLE);
    assign bus.dbg_state = state;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            operand      <= '0;
            rem          <= '0;
            idx          <= '0;
            bus.out_valid <= 1'b0;
            bus.out_num  <= '0;
            bus.out_even <= 1'b0;
            bus.out_div  <= 1'b0;
            bus.out_rem  <= '0;
            bus.even_cnt <= '0;
            bus.odd_cnt  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.in_valid) begin
                        operand <= bus.in_num;
                        rem     <= '0;
                        idx     <= IDX_W'(WIDTH - 1);
                        state   <= CALC;
                    end
                end
                CALC: begin
                    rem <= rem_next[WIDTH-1:0];
                    if (idx == '0) begin
                        // Last bit step: publish the whole result at once.
                        state         <= DONE;
                        bus.out_valid <= 1'b1;
                        bus.out_num   <= operand;
                        bus.out_even  <= ~operand[0];
                        bus.out_rem   <= rem_next[WIDTH-1:0];
                        bus.out_div   <= (rem_next == '0);
                    end else begin
                        idx <= idx - IDX_W'(1);
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        bus.out_valid <= 1'b0;
                        state         <= IDLE;
                        if (bus.out_even) begin
                            if (bus.even_cnt != '1) begin
                                bus.even_cnt <= bus.even_cnt + CNT_W'(1);
                            end
                        end else begin
                            if (bus.odd_cnt != '1) begin
                                bus.odd_cnt <= bus.odd_cnt + CNT_W'(1);
                            end
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

`ifdef NUM_CLASSIFY_DISPLAY_EN
    always @(posedge clk) begin
        if (!rst && bus.out_valid && bus.out_ready) begin
            $display("num_classify_stream: num=%0d %s %s rem=%0d",
                     bus.out_num,
                     bus.out_even ? "even" : "odd",
                     bus.out_div ? "divisible" : "not divisible",
                     bus.out_rem);
        end
    end
`endif

endmodule

// File: doc/num_classify_stream.md
Name: num_classify_stream

Overview:
- Streaming number classifier, the parametrised successor to the single-shot even/odd checker.
- Accepts one WIDTH-bit number per valid/ready handshake.
- Reports even/odd and divisibility by a parametrised DIVISOR, with the remainder from an iterative shift-subtract divider.
- Keeps running even/odd totals.
- Sits between a number source and any consumer or logging block.

Parameters:
- WIDTH, 32, operand width in bits (≥2).
- DIVISOR, 3, constant divisor (1 ≤ DIVISOR ≤ 2^WIDTH-1); DIVISOR=0 is an elaboration error.
- CNT_W, 16, width of the saturating even/odd counters.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous active-high reset
- in_valid  in  1  in_num is valid
- in_ready  out  1  block can accept a number
- in_num  in  WIDTH  number to classify
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts result
- out_num  out  WIDTH  echoed input number
- out_even  out  1  1 = even, 0 = odd
- out_div  out  1  1 = out_num divisible by DIVISOR
- out_rem  out  WIDTH  out_num mod DIVISOR
- even_cnt  out  CNT_W  count of even results delivered
- odd_cnt  out  CNT_W  count of odd results delivered

Behaviour:
- Clocking and reset: one clock, clk. Reset rst is asynchronous, active-high. Asserting rst forces IDLE immediately.
- Reset values: in_ready=1 once rst deasserts; out_valid=0; out_num=0; out_even=0; out_div=0; out_rem=0; even_cnt=0; odd_cnt=0; bit index=0.
- FSM states are IDLE, CALC and DONE. in_ready = (state==IDLE) and is registered-state decoded.
- IDLE:
  - On in_valid&&in_ready, capture in_num into an operand register.
  - Clear the partial remainder (WIDTH+1 bits internally) and set bit index = WIDTH-1.
  - Go to CALC.
- CALC, each cycle (restoring division, MSB first):
  - rem' = {rem, operand[idx]}.
  - If rem' ≥ DIVISOR, rem' -= DIVISOR.
  - After the bit-0 step, go to DONE.
  - Exactly WIDTH cycles are spent in CALC.
- Latency: out_valid rises WIDTH clock edges after the accepting edge.
- DONE:
  - out_valid=1. out_num, out_even=~out_num[0], out_rem (truncated to WIDTH bits, always < DIVISOR) and out_div=(out_rem==0) are all stable.
  - Outputs hold while out_ready=0, with no change under backpressure.
  - On out_valid&&out_ready, increment even_cnt or odd_cnt and return to IDLE.
- Throughput: one result per WIDTH+2 cycles. in_ready is 0 in CALC and DONE; inputs offered then are ignored, not lost (the source holds in_valid).
- Counters:
  - Increment only on the output handshake.
  - Saturate at 2^CNT_W-1 with no wrap.
  - Saturation of one counter does not affect the other.
- Zero input: even=1, div=1, rem=0.
- DIVISOR=1: div is always 1 and rem is always 0. DIVISOR=2: out_div==out_even.
- Reset mid-CALC or mid-DONE:
  - The in-flight number is discarded and no counter increments.
  - Outputs return to their reset values in the same cycle.
- Simultaneous out_ready and new in_valid in DONE: the output handshake completes and the new input is not accepted until the next cycle, when the block is in IDLE.
- No combinational path from in_* to out_*.

Optional Feature:
- Macro NUM_CLASSIFY_DISPLAY_EN.
- Defined: on each output handshake, print a simulation $display with out_num, even/odd, divisible/not, and remainder. This is the simulation-only logging the earlier checker did, but now once per result rather than on every input change.
- Undefined: no $display statements are compiled; RTL behaviour is identical.

Test Plan (WIDTH=8, DIVISOR=3, CNT_W=16 unless stated):
- in_num=9, out_ready=1 -> out_valid exactly 8 cycles after accept; even=0, div=1, rem=0; odd_cnt=1.
- in_num=10 -> even=1, div=0, rem=1; even_cnt=1. in_num=0 -> even=1, div=1, rem=0. in_num=255 -> even=0, div=1, rem=0.
- Backpressure: in_num=14, out_ready=0 for 5 cycles -> outputs hold (rem=2, div=0, even=1), in_ready=0, counters unchanged; raise out_ready -> one handshake, even_cnt +1, in_ready=1 next cycle.
- Back-to-back: hold in_valid with 4,7 -> second accepted only after first output handshake; results rem=1 then rem=1; even_cnt=1, odd_cnt=1.
- Reset mid-CALC: assert rst 3 cycles after accepting 17 -> out_valid=0, counters 0, in_ready=1 after release; the next input, 6, yields div=1, rem=0.
- Saturation with CNT_W=2: deliver 5 even numbers -> even_cnt=3 and stays 3, odd_cnt=0. With DIVISOR=1: in_num=77 -> div=1, rem=0.
